// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV32I immediate generator: opcode encodings and
// the immediate-format classification produced by the decoder.
package imm_gen_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_Z,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/imm_gen_type_decode.sv
// Classifies an RV32I instruction into its immediate format from the opcode
// and funct3[2] (which separates CSR register forms from CSR immediate forms).
module imm_type_decode
  import imm_gen_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_funct3_msb,
  output imm_type_e  o_type
);

  always_comb begin
    o_type = IMM_NONE;
    case (i_opcode)
      OPC_OPIMM, OPC_LOAD, OPC_JALR: o_type = IMM_I;
      OPC_STORE:                     o_type = IMM_S;
      OPC_BRANCH:                    o_type = IMM_B;
      OPC_LUI, OPC_AUIPC:            o_type = IMM_U;
      OPC_JAL:                       o_type = IMM_J;
      // CSRR*I carry a 5-bit zero-extended immediate in the rs1 field
      OPC_SYSTEM:                    o_type = i_funct3_msb ? IMM_Z : IMM_I;
      default:                       o_type = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator. Combinational by default; defining
// IMMGEN_OUTPUT_REG_EN adds an output register with one cycle of latency.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  imm_type_e w_type_p0;
  logic signed [XLEN-1:0] w_imm_p0;

  function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext21(input logic signed [20:0] v);
    return XLEN'(v);
  endfunction

  imm_type_decode u_decode (
    .i_opcode    (inst[6:0]),
    .i_funct3_msb(inst[14]),
    .o_type      (w_type_p0)
  );

  always_comb begin
    w_imm_p0 = '0;
    case (w_type_p0)
      IMM_I:   w_imm_p0 = sext12(inst[31:20]);
      IMM_S:   w_imm_p0 = sext12({inst[31:25], inst[11:7]});
      IMM_B:   w_imm_p0 = sext13({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      IMM_U:   w_imm_p0 = {inst[31:12], 12'b0};
      IMM_J:   w_imm_p0 = sext21({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      IMM_Z:   w_imm_p0 = {27'b0, inst[19:15]};
      default: w_imm_p0 = '0;
    endcase
  end

`ifdef IMMGEN_OUTPUT_REG_EN
  logic [XLEN-1:0] r_imm_p1;

  // ---- stage p0 -> p1 boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_imm_p1 <= '0;
    else       r_imm_p1 <= w_imm_p0;
  end

  assign imm = r_imm_p1;
`else
  logic w_unused;
  assign w_unused = clk ^ reset;
  assign imm      = w_imm_p0;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed RV32I encodings, reset behaviour
// and a randomized opcode sweep against a behavioural immediate model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [31:0] imm;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  imm_gen dut (
    .clk  (clk),
    .reset(reset),
    .inst (inst),
    .imm  (imm)
  );

  always #5 clk = ~clk;

  // Reference: field extraction written as signed integer arithmetic
  function automatic logic [31:0] model(input logic [31:0] w);
    int v;
    logic [6:0] op;
    op = w[6:0];
    v  = 0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (op == 7'h73 && !w[14]))
      v = int'($signed(w[31:20]));
    else if (op == 7'h23)
      v = int'($signed({w[31:25], w[11:7]}));
    else if (op == 7'h63)
      v = 2 * int'($signed({w[31], w[7], w[30:25], w[11:8]}));
    else if (op == 7'h37 || op == 7'h17)
      v = int'(w[31:12]) * 4096;
    else if (op == 7'h6F)
      v = 2 * int'($signed({w[31], w[19:12], w[20], w[30:21]}));
    else if (op == 7'h73)
      v = int'(w[19:15]);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Single compare process: every enabled cycle, sampled 1ns after posedge
  always @(posedge clk) begin
    #1;
    if (chk_en && !reset) check("model", imm, model(inst));
  end

  task automatic apply(input logic [31:0] w);
    @(negedge clk);
    inst = w;
    @(posedge clk);
    #1;
  endtask

  typedef struct { string name; logic [31:0] w; logic [31:0] exp; } vec_t;
  vec_t dir[7];

  initial begin
    logic [6:0]  opcs[12];
    logic [31:0] rnd;
    dir[0] = '{"addi_m1", 32'hFFF00093, 32'hFFFFFFFF};
    dir[1] = '{"sw_8",    32'h0020A423, 32'h00000008};
    dir[2] = '{"beq_m4",  32'hFE000EE3, 32'hFFFFFFFC};
    dir[3] = '{"lui",     32'h123450B7, 32'h12345000};
    dir[4] = '{"jal_2k",  32'h001000EF, 32'h00000800};
    dir[5] = '{"csrrwi",  32'h51E2D073, 32'h00000005};
    dir[6] = '{"add",     32'h002081B3, 32'h00000000};
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
             7'h33, 7'h0F, 7'h00};

    reset = 1'b1;
    inst  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    foreach (dir[i]) begin
      apply(dir[i].w);
      check(dir[i].name, imm, dir[i].exp);
    end

`ifdef IMMGEN_OUTPUT_REG_EN
    apply(32'h123450B7);
    chk_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", imm, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    inst  = 32'hFFF00093;
    @(posedge clk);
    #1;
    check("post_reset", imm, 32'hFFFFFFFF);
    chk_en = 1'b1;
`endif

    // Randomized sweep; stops at the first mismatch
    for (int n = 0; n < 800 && bad == 0; n++) begin
      rnd = $urandom;
      int_sel: begin
        int k;
        k = $urandom_range(0, 11);
        if (k == 11) apply(rnd);
        else         apply({rnd[31:7], opcs[k]});
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
